mem_stall_ctrl: RTL and testbench
=================================

# mem_stall_ctrl

Stall-source controller for the CPU data-memory port. It turns a single-cycle pipeline load/store into a valid/ready request to a multi-cycle memory (cache or BRAM wrapper). It holds `stall` high until the access completes, then presents the captured load data stable for the cycle in which the pipeline advances. Downstream stall-hold logic consumes this block's `stall` output.

## Interface
- `DWIDTH`, 32, data width in bits
- `AWIDTH`, 32, address width in bits
- `clk` input 1, the single clock; all state updates on its rising edge
- `reset` input 1, asynchronous, active-high
- `cpu_re` input 1, load request from the pipeline (memory stage)
- `cpu_we` input DWIDTH/8, byte write mask; any nonzero bit means store
- `cpu_addr` input AWIDTH, access address
- `cpu_wdata` input DWIDTH, store data
- `cpu_rdata` output DWIDTH, registered load data
- `stall` output 1, freezes the pipeline while high
- `mem_req_valid` output 1, request valid toward memory
- `mem_req_ready` input 1, memory accepts the request
- `mem_req_rw` output 1, 1 = write, 0 = read
- `mem_req_addr` output AWIDTH, latched address
- `mem_req_wdata` output DWIDTH, latched store data
- `mem_req_wmask` output DWIDTH/8, latched byte mask
- `mem_resp_valid` input 1, read response valid
- `mem_resp_data` input DWIDTH, read response data
- `stall_count` output 32, free-running count of stalled cycles

## Operation
- **Access definition:** `access = cpu_re | (|cpu_we)`. If both a load and a store are requested, the store wins and `cpu_re` is ignored.
- **FSM states:** IDLE, REQ, WAIT, DONE.
- **IDLE:**
  - If `access` is high, latch `cpu_addr`, `cpu_wdata`, `cpu_we`, and the rw bit into request registers, then go to REQ.
  - Otherwise stay in IDLE.
- **REQ:**
  - `mem_req_valid` = 1, and all `mem_req_*` outputs are driven from the latched registers. They stay constant until accepted.
  - When `mem_req_ready` = 1, a write goes to DONE and a read goes to WAIT.
  - Otherwise stay in REQ. `valid` never drops before acceptance.
- **WAIT:** when `mem_resp_valid` = 1, capture `mem_resp_data` into `cpu_rdata` and go to DONE. Otherwise stay in WAIT.
- **DONE:**
  - `stall` = 0 and the pipeline advances at the end of this cycle.
  - CPU inputs are ignored here, because they still belong to the completed instruction. The next state is always IDLE.
- **`stall` is combinational:** `(IDLE & access) | REQ | WAIT`.
- **`cpu_rdata` hold rule:** it changes only on a captured read response and otherwise holds its value indefinitely. Writes do not alter it.
- **`mem_resp_valid` outside WAIT** is ignored. Memory must not respond in its acceptance cycle.
- **`stall_count`:** increments by 1 on every edge where `stall` = 1 and wraps at 2^32 − 1 → 0.
- **Unused request fields:** `mem_req_wdata` and `mem_req_wmask` are don't-care for reads but still driven from the latched registers.

## Timing
- **Reset values** (applied asynchronously the moment `reset` rises, regardless of state):
  - state = IDLE
  - `cpu_rdata` = 0, `stall_count` = 0
  - request registers = 0, so `mem_req_valid` = 0, `mem_req_rw` = 0, `mem_req_addr` = 0, `mem_req_wdata` = 0, `mem_req_wmask` = 0
  - `stall` = `access` (combinational from IDLE)
- **Reset mid-transaction:** an in-flight request or response is abandoned, with no replay. The memory side must also be reset.
- **Minimum read** (`ready` in the first REQ cycle, response one cycle later):
  - cycle 0: IDLE with `access`, `stall` = 1
  - cycle 1: REQ, accepted
  - cycle 2: WAIT, response arrives
  - cycle 3: DONE, `stall` = 0
  - Result: 3 stalled cycles, and `cpu_rdata` is valid from cycle 3 onward.
- **Minimum write:** cycle 0 IDLE, cycle 1 REQ accepted, cycle 2 DONE. Result: 2 stalled cycles.
- **Each extra cycle** of `ready` low or `resp` late adds exactly one stalled cycle.
- **Back-to-back accesses:** the earliest next `access` is recognised in the cycle after DONE.
- **Latency to memory:** `mem_req_valid` asserts one cycle after `access` is first seen in IDLE.

## Test plan
- **Single read:** `cpu_re` = 1 at addr 0x100; `ready` = 1 immediately; `resp` of 0xDEADBEEF one cycle later.
  - `mem_req_rw` = 0 and `mem_req_addr` = 0x100.
  - `stall` is high for exactly 3 cycles.
  - `cpu_rdata` = 0xDEADBEEF in DONE and holds afterwards.
  - `stall_count` = 3.
- **Store with backpressure:** `cpu_we` = 4'b0011, `wdata` = 0x1234, `ready` held low for 4 cycles.
  - `mem_req_valid` is high for 5 cycles with `wmask` = 0011 and `wdata` = 0x1234 stable throughout.
  - `stall` is high for 6 cycles.
  - `cpu_rdata` is unchanged.
- **Load + store together:** `cpu_re` = 1 and `cpu_we` = 4'hF in the same cycle.
  - `mem_req_rw` = 1.
  - The FSM completes via REQ→DONE with no WAIT.
- **Late/spurious response:** pulse `mem_resp_valid` with 0xBAD during REQ, then send 0x55 after 5 WAIT cycles.
  - `cpu_rdata` = 0x55; 0xBAD is never captured.
  - `stall` is high for 8 cycles.
- **Reset mid-read:** assert `reset` during WAIT.
  - `mem_req_valid`, `cpu_rdata` and `stall_count` go to 0 immediately, without waiting for a clock edge.
  - The FSM is in IDLE.
  - With `access` = 0, `stall` = 0.
- **Back-to-back:** issue a read, then a write at the next instruction.
  - The second `mem_req_valid` rises exactly 2 cycles after DONE.
  - `stall` is low only during DONE and the following IDLE cycle's evaluation edge.

Source files
------------

// File: rtl/mem_stall_ctrl.sv
// mem_stall_ctrl: turns a single-cycle pipeline load/store into a valid/ready
// memory transaction. It stalls the pipeline until the access completes, then
// releases it for exactly one DONE cycle while the captured load data is held.
module mem_stall_ctrl #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cpu_re,
    input  logic [DWIDTH/8-1:0] cpu_we,
    input  logic [AWIDTH-1:0]   cpu_addr,
    input  logic [DWIDTH-1:0]   cpu_wdata,
    output logic [DWIDTH-1:0]   cpu_rdata,
    output logic                stall,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_req_rw,
    output logic [AWIDTH-1:0]   mem_req_addr,
    output logic [DWIDTH-1:0]   mem_req_wdata,
    output logic [DWIDTH/8-1:0] mem_req_wmask,
    input  logic                mem_resp_valid,
    input  logic [DWIDTH-1:0]   mem_resp_data,
    output logic [31:0]         stall_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [AWIDTH-1:0]     addr_q;
    logic [DWIDTH-1:0]     wdata_q;
    logic [DWIDTH/8-1:0]   wmask_q;
    logic                  rw_q;
    logic [DWIDTH-1:0]     rdata_q, rdata_d;
    logic [31:0]           count_q, count_d;

    logic access;
    logic is_store;
    logic capture;

    // A store takes priority over a simultaneous load.
    assign is_store = |cpu_we;
    assign access   = cpu_re | is_store;
    // The request is latched only from IDLE; CPU inputs in other states belong
    // to the instruction already in flight.
    assign capture  = (state_q == IDLE) && access;

    // Next-state logic and the combinational stall / data-hold decisions.
    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        stall   = 1'b0;
        unique case (state_q)
            IDLE: begin
                stall = access;
                if (access) state_d = REQ;
            end
            REQ: begin
                stall = 1'b1;
                if (mem_req_ready) state_d = rw_q ? DONE : WAIT;
            end
            WAIT: begin
                stall = 1'b1;
                if (mem_resp_valid) begin
                    rdata_d = mem_resp_data;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Counter wraps naturally at 2^32.
        count_d = stall ? count_q + 32'd1 : count_q;
    end

    // State, load data and stall counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rdata_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            count_q <= count_d;
        end
    end

    // Request registers hold the access stable for the whole handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            rw_q    <= 1'b0;
        end else if (capture) begin
            addr_q  <= cpu_addr;
            wdata_q <= cpu_wdata;
            wmask_q <= cpu_we;
            rw_q    <= is_store;
        end
    end

    assign mem_req_valid = (state_q == REQ);
    assign mem_req_rw    = rw_q;
    assign mem_req_addr  = addr_q;
    assign mem_req_wdata = wdata_q;
    assign mem_req_wmask = wmask_q;
    assign cpu_rdata     = rdata_q;
    assign stall_count   = count_q;

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Directed testbench for mem_stall_ctrl. Inputs change 1 time unit after the
// rising edge; outputs are sampled 1 time unit later, well before the next edge.
module tb_mem_stall_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_re;
    logic [3:0]  cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        stall;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_rw;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic [31:0] stall_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_stall_ctrl #(.DWIDTH(32), .AWIDTH(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_re         (cpu_re),
        .cpu_we         (cpu_we),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_rdata      (cpu_rdata),
        .stall          (stall),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_rw     (mem_req_rw),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_wmask  (mem_req_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .stall_count    (stall_count)
    );

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        cpu_re = 1'b0; cpu_we = 4'h0; cpu_addr = '0; cpu_wdata = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
        reset = 1'b0;
        #1 reset = 1'b1;
        #2;
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %b expected 0", stall); end
        n_vec++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b expected 0", mem_req_valid); end
        n_vec++; if (cpu_rdata !== 32'h0) begin n_err++; $display("FAIL rst_rdata: got %h expected 0", cpu_rdata); end
        n_vec++; if (stall_count !== 32'h0) begin n_err++; $display("FAIL rst_count: got %0d expected 0", stall_count); end
        n_vec++; if (mem_req_addr !== 32'h0 || mem_req_rw !== 1'b0 || mem_req_wmask !== 4'h0 || mem_req_wdata !== 32'h0)
            begin n_err++; $display("FAIL rst_reqregs: got addr %h rw %b mask %h wdata %h expected all 0", mem_req_addr, mem_req_rw, mem_req_wmask, mem_req_wdata); end
        cpu_re = 1'b1;
        #1;
        n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL rst_stall_access: got %b expected 1", stall); end
        cpu_re = 1'b0;
        next_cycle;
        reset = 1'b0;
        next_cycle;
    endtask

    task automatic test_single_read;
        int stalls = 0;
        for (int i = 0; i < 4; i++) begin
            cpu_re         = (i <= 2);
            cpu_addr       = 32'h100;
            mem_req_ready  = (i == 1);
            mem_resp_valid = (i == 2);
            mem_resp_data  = (i == 2) ? 32'hDEADBEEF : 32'h0;
            #1;
            if (stall) stalls++;
            if (i == 1) begin
                n_vec++; if (mem_req_valid !== 1'b1) begin n_err++; $display("FAIL rd_valid: got %b expected 1", mem_req_valid); end
                n_vec++; if (mem_req_rw !== 1'b0) begin n_err++; $display("FAIL rd_rw: got %b expected 0", mem_req_rw); end
                n_vec++; if (mem_req_addr !== 32'h100) begin n_err++; $display("FAIL rd_addr: got %h expected 100", mem_req_addr); end
            end
            if (i == 3) begin
                n_vec++; if (cpu_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_rdata_done: got %h expected deadbeef", cpu_rdata); end
                n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL rd_stall_done: got %b expected 0", stall); end
            end
            next_cycle;
        end
        mem_resp_valid = 1'b0; mem_req_ready = 1'b0;
        #1;
        n_vec++; if (stalls != 3) begin n_err++; $display("FAIL rd_stall_cycles: got %0d expected 3", stalls); end
        n_vec++; if (cpu_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_rdata_hold: got %h expected deadbeef", cpu_rdata); end
        n_vec++; if (stall_count !== 32'd3) begin n_err++; $display("FAIL rd_count: got %0d expected 3", stall_count); end
    endtask

    task automatic test_store_backpressure;
        int stalls = 0;
        int valids = 0;
        for (int i = 0; i < 7; i++) begin
            cpu_re        = 1'b0;
            cpu_we        = (i <= 5) ? 4'b0011 : 4'b0000;
            cpu_wdata     = 32'h1234;
            cpu_addr      = 32'h200;
            mem_req_ready = (i == 5);
            #1;
            if (stall) stalls++;
            if (mem_req_valid) begin
                valids++;
                n_vec++; if (mem_req_wmask !== 4'b0011) begin n_err++; $display("FAIL st_wmask c%0d: got %b expected 0011", i, mem_req_wmask); end
                n_vec++; if (mem_req_wdata !== 32'h1234) begin n_err++; $display("FAIL st_wdata c%0d: got %h expected 1234", i, mem_req_wdata); end
                n_vec++; if (mem_req_rw !== 1'b1) begin n_err++; $display("FAIL st_rw c%0d: got %b expected 1", i, mem_req_rw); end
            end
            next_cycle;
        end
        mem_req_ready = 1'b0;
        #1;
        n_vec++; if (stalls != 6) begin n_err++; $display("FAIL st_stall_cycles: got %0d expected 6", stalls); end
        n_vec++; if (valids != 5) begin n_err++; $display("FAIL st_valid_cycles: got %0d expected 5", valids); end
        n_vec++; if (cpu_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL st_rdata_keep: got %h expected deadbeef", cpu_rdata); end
        n_vec++; if (stall_count !== 32'd9) begin n_err++; $display("FAIL st_count: got %0d expected 9", stall_count); end
    endtask

    task automatic test_load_store_together;
        for (int i = 0; i < 3; i++) begin
            cpu_re        = (i <= 1);
            cpu_we        = (i <= 1) ? 4'hF : 4'h0;
            cpu_addr      = 32'h300;
            cpu_wdata     = 32'hCAFEF00D;
            mem_req_ready = (i == 1);
            #1;
            if (i == 1) begin
                n_vec++; if (mem_req_valid !== 1'b1) begin n_err++; $display("FAIL ls_valid: got %b expected 1", mem_req_valid); end
                n_vec++; if (mem_req_rw !== 1'b1) begin n_err++; $display("FAIL ls_rw: got %b expected 1", mem_req_rw); end
                n_vec++; if (mem_req_wmask !== 4'hF) begin n_err++; $display("FAIL ls_wmask: got %h expected f", mem_req_wmask); end
            end
            if (i == 2) begin
                n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL ls_done_no_wait: got stall %b expected 0", stall); end
            end
            next_cycle;
        end
        mem_req_ready = 1'b0;
        #1;
        n_vec++; if (stall_count !== 32'd11) begin n_err++; $display("FAIL ls_count: got %0d expected 11", stall_count); end
    endtask

    task automatic test_spurious_response;
        int stalls = 0;
        for (int i = 0; i < 9; i++) begin
            cpu_re         = (i <= 7);
            cpu_we         = 4'h0;
            cpu_addr       = 32'h400;
            mem_req_ready  = (i == 2);
            mem_resp_valid = (i == 1) || (i == 7) || (i == 8);
            mem_resp_data  = (i == 7) ? 32'h55 : 32'hBAD;
            #1;
            if (stall) stalls++;
            if (i == 2) begin
                n_vec++; if (cpu_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL sp_req_ignored: got %h expected deadbeef", cpu_rdata); end
            end
            if (i == 8) begin
                n_vec++; if (cpu_rdata !== 32'h55) begin n_err++; $display("FAIL sp_rdata: got %h expected 55", cpu_rdata); end
            end
            next_cycle;
        end
        mem_resp_valid = 1'b0; mem_req_ready = 1'b0;
        #1;
        n_vec++; if (stalls != 8) begin n_err++; $display("FAIL sp_stall_cycles: got %0d expected 8", stalls); end
        n_vec++; if (cpu_rdata !== 32'h55) begin n_err++; $display("FAIL sp_done_ignored: got %h expected 55", cpu_rdata); end
        n_vec++; if (stall_count !== 32'd19) begin n_err++; $display("FAIL sp_count: got %0d expected 19", stall_count); end
    endtask

    task automatic test_reset_mid_read;
        for (int i = 0; i < 2; i++) begin
            cpu_re = 1'b1; cpu_addr = 32'h500; mem_req_ready = (i == 1);
            #1;
            next_cycle;
        end
        mem_req_ready = 1'b0;
        #1;
        n_vec++; if (stall !== 1'b1 || stall_count !== 32'd21) begin n_err++; $display("FAIL mr_pre_wait: got stall %b count %0d expected 1 21", stall, stall_count); end
        reset  = 1'b1;
        cpu_re = 1'b0;
        #1;
        n_vec++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL mr_valid: got %b expected 0", mem_req_valid); end
        n_vec++; if (cpu_rdata !== 32'h0) begin n_err++; $display("FAIL mr_rdata: got %h expected 0", cpu_rdata); end
        n_vec++; if (stall_count !== 32'h0) begin n_err++; $display("FAIL mr_count: got %0d expected 0", stall_count); end
        n_vec++; if (mem_req_addr !== 32'h0) begin n_err++; $display("FAIL mr_addr: got %h expected 0", mem_req_addr); end
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL mr_stall: got %b expected 0", stall); end
        next_cycle;
        reset = 1'b0;
        next_cycle;
        n_vec++; if (stall !== 1'b0 || mem_req_valid !== 1'b0) begin n_err++; $display("FAIL mr_idle: got stall %b valid %b expected 0 0", stall, mem_req_valid); end
        cpu_re = 1'b1;
        #1;
        n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL mr_idle_access: got %b expected 1", stall); end
        cpu_re = 1'b0;
        next_cycle;
    endtask

    task automatic test_back_to_back;
        logic exp_stall [8];
        logic prev_valid = 1'b0;
        int   rises = 0;
        int   rise2 = -1;
        exp_stall = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            cpu_re         = (i <= 3);
            cpu_we         = (i >= 4 && i <= 6) ? 4'hF : 4'h0;
            cpu_addr       = (i <= 3) ? 32'h600 : 32'h604;
            cpu_wdata      = 32'h99;
            mem_req_ready  = (i == 1) || (i == 5);
            mem_resp_valid = (i == 2);
            mem_resp_data  = 32'h77;
            #1;
            n_vec++; if (stall !== exp_stall[i]) begin n_err++; $display("FAIL bb_stall c%0d: got %b expected %b", i, stall, exp_stall[i]); end
            if (mem_req_valid && !prev_valid) begin
                rises++;
                if (rises == 2) rise2 = i;
            end
            prev_valid = mem_req_valid;
            if (i == 5) begin
                n_vec++; if (mem_req_rw !== 1'b1 || mem_req_addr !== 32'h604) begin n_err++; $display("FAIL bb_second_req: got rw %b addr %h expected 1 604", mem_req_rw, mem_req_addr); end
            end
            if (i == 6) begin
                n_vec++; if (cpu_rdata !== 32'h77) begin n_err++; $display("FAIL bb_rdata: got %h expected 77", cpu_rdata); end
            end
            next_cycle;
        end
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        #1;
        n_vec++; if (rise2 != 5) begin n_err++; $display("FAIL bb_valid_rise: got cycle %0d expected 5", rise2); end
        n_vec++; if (stall_count !== 32'd5) begin n_err++; $display("FAIL bb_count: got %0d expected 5", stall_count); end
    endtask

    initial begin
        test_reset;
        test_single_read;
        test_store_backpressure;
        test_load_store_together;
        test_spurious_response;
        test_reset_mid_read;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
